muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It takes the same rs1/rs2 operands as the ALU (`A`, `B`) plus instruction funct3. It produces a 32-bit result for the writeback mux through a valid/ready handshake. While it is busy, hazard control stalls the pipeline using `in_ready`/`out_valid`.

---
 rtl/muldiv_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle on operand magnitudes,
// sign fixup afterwards, result returned through a valid/ready handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Out
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
    state_t state, state_nx;
    logic [2:0]        funct_q;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [2*XLEN-1:0] acc;
    logic [5:0]        cnt;
    logic              accept, sgn_a, sgn_b, div_zero, div_ovf, special;
    logic [XLEN-1:0]   abs_a, abs_b, special_res, quot, rem, fix_res;
    logic [XLEN:0]     mul_sum, rem_sh, div_diff;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod;

    assign in_ready    = state == IDLE;
    assign accept      = in_valid && in_ready && !kill;
    assign sgn_a       = funct[2] ? ~funct[0] : (funct[1:0] != 2'b11);
    assign sgn_b       = funct[2] ? ~funct[0] : ~funct[1];
    assign abs_a       = (sgn_a && A[XLEN-1]) ? -A : A;
    assign abs_b       = (sgn_b && B[XLEN-1]) ? -B : B;
    assign div_zero    = funct[2] && B == '0;
    assign div_ovf     = funct[2] && !funct[0] && A == {1'b1, {(XLEN-1){1'b0}}} && B == '1;
    assign special     = div_zero || div_ovf;
    // The overflow quotient equals the dividend itself (most negative value)
    assign special_res = div_zero ? (funct[1] ? A : '1) : (funct[1] ? '0 : A);

    // Shift-add: high half accumulates the multiplicand, multiplier bits shift out of the low half
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_nx   = {mul_sum, acc[XLEN-1:1]};
    // Restoring divide: a borrow out of the 33-bit trial subtract means restore
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign div_diff = rem_sh - {1'b0, mag_b};
    assign div_nx   = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod    = (neg_a ^ neg_b) ? -acc : acc;
    assign quot    = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem     = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_res = !funct_q[2] ? (funct_q[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                                 : (funct_q[1] ? rem : quot);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (kill) state_nx = IDLE;
        else begin
            case (state)
                IDLE:    state_nx = accept ? (special ? DONE : CALC) : IDLE;
                CALC:    state_nx = (cnt == 6'(XLEN-1)) ? FIXUP : CALC;
                FIXUP:   state_nx = DONE;
                DONE:    state_nx = (out_valid && out_ready) ? IDLE : DONE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            funct_q   <= '0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            Out       <= '0;
            out_valid <= 1'b0;
        end else begin
            // out_valid follows entry into DONE by one cycle
            out_valid <= !kill && state == DONE && !(out_valid && out_ready);
            if (accept) begin
                funct_q <= funct;
                neg_a   <= sgn_a && A[XLEN-1];
                neg_b   <= sgn_b && B[XLEN-1];
                mag_a   <= abs_a;
                mag_b   <= abs_b;
                acc     <= {{XLEN{1'b0}}, funct[2] ? abs_a : abs_b};
                cnt     <= '0;
                if (special) Out <= special_res;
            end
            if (state == CALC) begin
                acc <= funct_q[2] ? div_nx : mul_nx;
                cnt <= cnt + 6'd1;
            end
            if (state == FIXUP) Out <= fix_res;
        end
    end
endmodule
